// File: rtl/vend_pkg.sv
// Shared types and default constants for the vending credit/dispense controller.
package vend_pkg;

  localparam int unsigned CREDIT_W         = 4;
  localparam int unsigned PRICE_COFFEE_DEF = 2;
  localparam int unsigned PRICE_SPRITE_DEF = 3;
  localparam int unsigned MAX_CREDIT_DEF   = 9;
  localparam int unsigned DISPENSE_CYC_DEF = 100;
  localparam int unsigned GAP_CYC_DEF      = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPENSE = 2'd1,
    GAP      = 2'd2,
    REFUND   = 2'd3
  } state_e;

  // Sizes the shared duration counter for the longer of the two timed states.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vend_edge_det.sv
// Registers one level input and flags its rising edge (cur & ~prev).
module vend_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise_c
);

  logic cur;
  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur  <= 1'b0;
      prev <= 1'b0;
    end else begin
      cur  <= din;
      prev <= cur;
    end
  end

  assign rise_c = cur & ~prev;

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Credit counter and coffee/sprite dispense arbiter for the shared spout.
// Optional coin-return feature: define VEND_REFUND_EN.
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned PRICE_COFFEE = PRICE_COFFEE_DEF,
  parameter int unsigned PRICE_SPRITE = PRICE_SPRITE_DEF,
  parameter int unsigned MAX_CREDIT   = MAX_CREDIT_DEF,
  parameter int unsigned DISPENSE_CYC = DISPENSE_CYC_DEF,
  parameter int unsigned GAP_CYC      = GAP_CYC_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_coin,
  input  logic                i_coffee,
  input  logic                i_sprite,
`ifdef VEND_REFUND_EN
  input  logic                i_refund,
  output logic                o_refund,
`endif
  output logic                o_led_coffee,
  output logic                o_led_sprite,
  output logic                o_coffee,
  output logic                o_sprite,
  output logic                o_busy,
  output logic                o_reject,
  output logic [CREDIT_W-1:0] o_credit
);

  localparam int unsigned CNT_W = $clog2(max_u(DISPENSE_CYC, GAP_CYC) + 1);
  localparam int unsigned SUM_W = CREDIT_W + 1;

  logic coin_rise, coffee_rise, sprite_rise;

  state_e              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic                rr_sprite, rr_sprite_nx;
  logic                sel_sprite, sel_sprite_nx;
  logic [CREDIT_W-1:0] deduct;
  logic [SUM_W-1:0]    add_sum, sum;
  logic [CREDIT_W-1:0] credit_nx;
  logic                reject_nx;
  logic                ok_coffee, ok_sprite, grant_sprite;

  vend_edge_det u_ed_coin   (.clk(clk), .rst(rst), .din(i_coin),   .rise_c(coin_rise));
  vend_edge_det u_ed_coffee (.clk(clk), .rst(rst), .din(i_coffee), .rise_c(coffee_rise));
  vend_edge_det u_ed_sprite (.clk(clk), .rst(rst), .din(i_sprite), .rise_c(sprite_rise));

`ifdef VEND_REFUND_EN
  logic refund_rise;
  logic refund_nx;

  vend_edge_det u_ed_refund (.clk(clk), .rst(rst), .din(i_refund), .rise_c(refund_rise));
`endif

  // Next-state, arbitration and credit arithmetic.
  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    rr_sprite_nx  = rr_sprite;
    sel_sprite_nx = sel_sprite;
    deduct        = '0;
`ifdef VEND_REFUND_EN
    refund_nx     = 1'b0;
`endif

    ok_coffee    = (state == IDLE) && coffee_rise && (o_credit >= CREDIT_W'(PRICE_COFFEE));
    ok_sprite    = (state == IDLE) && sprite_rise && (o_credit >= CREDIT_W'(PRICE_SPRITE));
    grant_sprite = ok_sprite && (!ok_coffee || rr_sprite);
    add_sum      = SUM_W'(o_credit) + SUM_W'(coin_rise);

    case (state)
      IDLE: begin
        if (ok_coffee || ok_sprite) begin
          state_nx      = DISPENSE;
          cnt_nx        = CNT_W'(DISPENSE_CYC - 1);
          sel_sprite_nx = grant_sprite;
          rr_sprite_nx  = ~grant_sprite;
          deduct        = grant_sprite ? CREDIT_W'(PRICE_SPRITE) : CREDIT_W'(PRICE_COFFEE);
        end
`ifdef VEND_REFUND_EN
        else if (refund_rise && (o_credit != '0)) begin
          state_nx  = REFUND;
          refund_nx = 1'b1;
          deduct    = CREDIT_W'(1);
        end
`endif
      end
      DISPENSE: begin
        if (cnt == '0) begin
          state_nx = GAP;
          cnt_nx   = CNT_W'(GAP_CYC - 1);
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == '0) state_nx = IDLE;
        else           cnt_nx   = cnt - CNT_W'(1);
      end
`ifdef VEND_REFUND_EN
      // Alternate pulse-high / pulse-low; leave once nothing is left to return.
      REFUND: begin
        if (o_refund) begin
          if (add_sum == '0) state_nx = IDLE;
        end else begin
          refund_nx = 1'b1;
          deduct    = CREDIT_W'(1);
        end
      end
`endif
      default: state_nx = IDLE;
    endcase

    sum       = add_sum - SUM_W'(deduct);
    reject_nx = coin_rise && (sum > SUM_W'(MAX_CREDIT));
    credit_nx = (sum > SUM_W'(MAX_CREDIT)) ? CREDIT_W'(MAX_CREDIT) : sum[CREDIT_W-1:0];
  end

  // State and registered outputs, all derived from next-state values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      rr_sprite    <= 1'b0;
      sel_sprite   <= 1'b0;
      o_credit     <= '0;
      o_reject     <= 1'b0;
      o_busy       <= 1'b0;
      o_coffee     <= 1'b0;
      o_sprite     <= 1'b0;
      o_led_coffee <= 1'b0;
      o_led_sprite <= 1'b0;
`ifdef VEND_REFUND_EN
      o_refund     <= 1'b0;
`endif
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      rr_sprite    <= rr_sprite_nx;
      sel_sprite   <= sel_sprite_nx;
      o_credit     <= credit_nx;
      o_reject     <= reject_nx;
      o_busy       <= (state_nx != IDLE);
      o_coffee     <= (state_nx == DISPENSE) && !sel_sprite_nx;
      o_sprite     <= (state_nx == DISPENSE) && sel_sprite_nx;
      o_led_coffee <= (state_nx == IDLE) && (credit_nx >= CREDIT_W'(PRICE_COFFEE));
      o_led_sprite <= (state_nx == IDLE) && (credit_nx >= CREDIT_W'(PRICE_SPRITE));
`ifdef VEND_REFUND_EN
      o_refund     <= refund_nx;
`endif
    end
  end

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Self-checking bench for vend_dispense_ctrl: directed scenarios then random pin activity
// compared every cycle against a remaining-cycles reference model.
module tb_vend_dispense_ctrl;

  localparam int PC   = 2;
  localparam int PS   = 3;
  localparam int MAXC = 9;
  localparam int DCYC = 100;
  localparam int GCYC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_coin, i_coffee, i_sprite;
  logic       o_led_coffee, o_led_sprite, o_coffee, o_sprite, o_busy, o_reject;
  logic [3:0] o_credit;
`ifdef VEND_REFUND_EN
  logic       i_refund;
  logic       o_refund;
`endif

  always #5 clk = ~clk;

  vend_dispense_ctrl dut (
    .clk(clk),
    .rst(rst),
    .i_coin(i_coin),
    .i_coffee(i_coffee),
    .i_sprite(i_sprite),
`ifdef VEND_REFUND_EN
    .i_refund(i_refund),
    .o_refund(o_refund),
`endif
    .o_led_coffee(o_led_coffee),
    .o_led_sprite(o_led_sprite),
    .o_coffee(o_coffee),
    .o_sprite(o_sprite),
    .o_busy(o_busy),
    .o_reject(o_reject),
    .o_credit(o_credit)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: credit plus the number of cycles left in each busy phase.
  int m_credit, m_disp_left, m_gap_left;
  bit m_disp_sprite, m_rr_sprite, m_reject, m_ref_active, m_ref_hi;
  bit c_cur, c_prev, f_cur, f_prev, s_cur, s_prev, r_cur, r_prev;

  int cyc;
  int cnt_coffee, cnt_sprite, cnt_busy, cnt_reject, cnt_refund;
  int ref_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit m_busy();
    return (m_disp_left > 0) || (m_gap_left > 0) || m_ref_active;
  endfunction

  task automatic model_edge();
    bit ce, fe, se, re, ac, as, pick;
    int ded, tot;
    if (rst) begin
      m_credit = 0; m_disp_left = 0; m_gap_left = 0; m_disp_sprite = 0;
      m_rr_sprite = 0; m_reject = 0; m_ref_active = 0; m_ref_hi = 0;
      c_cur = 0; c_prev = 0; f_cur = 0; f_prev = 0;
      s_cur = 0; s_prev = 0; r_cur = 0; r_prev = 0;
      return;
    end
    ce  = c_cur && !c_prev;
    fe  = f_cur && !f_prev;
    se  = s_cur && !s_prev;
    re  = r_cur && !r_prev;
    ded = 0;
    if (m_disp_left > 0) begin
      m_disp_left--;
      if (m_disp_left == 0) m_gap_left = GCYC;
    end else if (m_gap_left > 0) begin
      m_gap_left--;
    end else if (m_ref_active) begin
      if (m_ref_hi) begin
        m_ref_hi = 0;
        if (m_credit + int'(ce) == 0) m_ref_active = 0;
      end else begin
        m_ref_hi = 1;
        ded      = 1;
      end
    end else begin
      ac = fe && (m_credit >= PC);
      as = se && (m_credit >= PS);
      if (ac || as) begin
        pick          = as && (!ac || m_rr_sprite);
        m_disp_left   = DCYC;
        m_disp_sprite = pick;
        m_rr_sprite   = !pick;
        ded           = pick ? PS : PC;
      end
`ifdef VEND_REFUND_EN
      else if (re && m_credit > 0) begin
        m_ref_active = 1;
        m_ref_hi     = 1;
        ded          = 1;
      end
`endif
    end
    tot      = m_credit - ded + int'(ce);
    m_reject = ce && (tot > MAXC);
    m_credit = (tot > MAXC) ? MAXC : tot;
    c_prev = c_cur; c_cur = i_coin;
    f_prev = f_cur; f_cur = i_coffee;
    s_prev = s_cur; s_cur = i_sprite;
`ifdef VEND_REFUND_EN
    r_prev = r_cur; r_cur = i_refund;
`endif
  endtask

  task automatic check_all();
    bit idle;
    idle = !m_busy();
    chk("credit",     32'(o_credit),     m_credit);
    chk("coffee",     32'(o_coffee),     int'(m_disp_left > 0 && !m_disp_sprite));
    chk("sprite",     32'(o_sprite),     int'(m_disp_left > 0 && m_disp_sprite));
    chk("busy",       32'(o_busy),       int'(!idle));
    chk("reject",     32'(o_reject),     int'(m_reject));
    chk("led_coffee", 32'(o_led_coffee), int'(idle && m_credit >= PC));
    chk("led_sprite", 32'(o_led_sprite), int'(idle && m_credit >= PS));
`ifdef VEND_REFUND_EN
    chk("refund",     32'(o_refund),     int'(m_ref_hi));
`endif
  endtask

  // One clock: model follows the edge, DUT is sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check_all();
    if (o_coffee === 1'b1) cnt_coffee++;
    if (o_sprite === 1'b1) cnt_sprite++;
    if (o_busy   === 1'b1) cnt_busy++;
    if (o_reject === 1'b1) cnt_reject++;
`ifdef VEND_REFUND_EN
    if (o_refund === 1'b1) begin
      cnt_refund++;
      ref_q.push_back(cyc);
    end
`endif
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic clear_counts();
    cnt_coffee = 0; cnt_sprite = 0; cnt_busy = 0; cnt_reject = 0; cnt_refund = 0;
    ref_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
  endtask

  task automatic coins(input int n);
    for (int k = 0; k < n; k++) begin
      i_coin = 1'b1; step();
      i_coin = 1'b0; step();
    end
  endtask

  initial begin
    cyc = 0;
    rst = 1'b1; i_coin = 1'b0; i_coffee = 1'b0; i_sprite = 1'b0;
`ifdef VEND_REFUND_EN
    i_refund = 1'b0;
`endif
    clear_counts();
    steps(3);
    chk("rst_credit", 32'(o_credit), 0);
    chk("rst_busy",   32'(o_busy),   0);
    chk("rst_led",    32'({o_led_coffee, o_led_sprite, o_coffee, o_sprite}), 0);
    rst = 1'b0;
    steps(2);

    // Two coins then coffee: 100 spout cycles, 104 busy cycles, credit consumed.
    coins(2); steps(2);
    chk("two_coins_credit", 32'(o_credit), 2);
    chk("two_coins_led_c",  32'(o_led_coffee), 1);
    clear_counts();
    i_coffee = 1'b1; step(); i_coffee = 1'b0;
    steps(129);
    chk("coffee_len",   32'(cnt_coffee), DCYC);
    chk("coffee_busy",  32'(cnt_busy), DCYC + GCYC);
    chk("coffee_after", 32'(o_credit), 0);

    // Unaffordable sprite is dropped.
    coins(1); steps(2);
    clear_counts();
    i_sprite = 1'b1; step(); i_sprite = 1'b0; steps(5);
    chk("poor_sprite_out", 32'(cnt_sprite), 0);
    chk("poor_credit",     32'(o_credit), 1);
    chk("poor_led_s",      32'(o_led_sprite), 0);

    // Simultaneous requests alternate, starting with coffee after reset.
    do_reset();
    coins(9); steps(2);
    chk("full_credit", 32'(o_credit), 9);
    i_coffee = 1'b1; i_sprite = 1'b1; step();
    i_coffee = 1'b0; i_sprite = 1'b0; steps(2);
    chk("rr1_coffee", 32'(o_coffee), 1);
    chk("rr1_credit", 32'(o_credit), 7);
    steps(110);
    i_coffee = 1'b1; i_sprite = 1'b1; step();
    i_coffee = 1'b0; i_sprite = 1'b0; steps(2);
    chk("rr2_sprite", 32'(o_sprite), 1);
    chk("rr2_credit", 32'(o_credit), 4);
    steps(110);

    // Coin at saturation is rejected with a single pulse.
    coins(5); steps(2);
    clear_counts();
    coins(1); steps(4);
    chk("sat_reject", 32'(cnt_reject), 1);
    chk("sat_credit", 32'(o_credit), 9);

    // Coin in the grant cycle; a second request during dispense is dropped.
    do_reset();
    coins(2); steps(2);
    clear_counts();
    i_coin = 1'b1; i_coffee = 1'b1; step();
    i_coin = 1'b0; i_coffee = 1'b0; steps(3);
    chk("coin_grant_credit", 32'(o_credit), 1);
    coins(2);
    i_coffee = 1'b1; step(); i_coffee = 1'b0;
    steps(120);
    chk("drop_len",    32'(cnt_coffee), DCYC);
    chk("drop_credit", 32'(o_credit), 3);

`ifdef VEND_REFUND_EN
    // Refund of three credits: three pulses two cycles apart.
    do_reset();
    coins(3); steps(2);
    clear_counts();
    i_refund = 1'b1; step(); i_refund = 1'b0; steps(12);
    chk("refund_cnt",    32'(cnt_refund), 3);
    if (ref_q.size() == 3) begin
      chk("refund_gap1", 32'(ref_q[1] - ref_q[0]), 2);
      chk("refund_gap2", 32'(ref_q[2] - ref_q[1]), 2);
    end
    chk("refund_credit", 32'(o_credit), 0);
    chk("refund_busy",   32'(o_busy), 0);
`endif

    // Reset mid-dispense drops the spout and the credit.
    do_reset();
    coins(3); steps(2);
    i_coffee = 1'b1; step(); i_coffee = 1'b0; steps(10);
    rst = 1'b1; step();
    chk("rst_mid_coffee", 32'(o_coffee), 0);
    chk("rst_mid_credit", 32'(o_credit), 0);
    rst = 1'b0; steps(2);

    // Random pin activity.
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(99) < 20) i_coin   = ~i_coin;
      if ($urandom_range(99) < 4)  i_coffee = ~i_coffee;
      if ($urandom_range(99) < 4)  i_sprite = ~i_sprite;
`ifdef VEND_REFUND_EN
      if ($urandom_range(99) < 3)  i_refund = ~i_refund;
`endif
      rst = ($urandom_range(1999) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
